// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: a one-hot T1..T6 ring counter with combinational
// microcode decode of the IR opcode into every datapath strobe.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       bus_sel,
  output logic       hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halt_q, halt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // A HLT seen in T4 latches the halt flag instead of advancing, freezing the ring at T4.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (run && !halt_q) begin
      if (state_q == T4 && opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else begin
        case (state_q)
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          T5:      state_d = T6;
          T6:      state_d = T1;
          default: state_d = T1;
        endcase
      end
    end
  end

  always_comb begin
    cp      = 1'b0;
    ep      = 1'b0;
    lm      = 1'b0;
    ce      = 1'b0;
    li      = 1'b0;
    ei      = 1'b0;
    la      = 1'b0;
    ea      = 1'b0;
    su      = 1'b0;
    eu      = 1'b0;
    lb      = 1'b0;
    lo      = 1'b0;
    bus_sel = 1'b0;
    if (!halt_q) begin
      case (state_q)
        T1: begin
          ep = 1'b1;
          lm = 1'b1;
        end
        T2: cp = 1'b1;
        T3: begin
          ce = 1'b1;
          li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea      = 1'b1;
              lo      = 1'b1;
              bus_sel = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          // ADD and SUB share the ALU write-back; only the subtract select differs.
          case (opcode)
            OP_ADD: begin
              eu = 1'b1;
              la = 1'b1;
            end
            OP_SUB: begin
              eu = 1'b1;
              la = 1'b1;
              su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign t_state = state_q;
  assign hlt     = halt_q;

endmodule
